// File: rtl/csd_nz_scanner_if.sv
// Digit-load, scan-control and result bundle between the CSD converter, the scanner
// and the shift-add coefficient unit.
interface csd_nz_scanner_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned MAX_NZ = 4,
    parameter int unsigned CNT_W  = 3
);
    logic                    wr_en;
    logic [IDX_W-1:0]        wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic [CNT_W-1:0]        nz_count;
    logic                    overflow;
    logic                    bad_digit;
    logic                    csd_err;
    logic [MAX_NZ*IDX_W-1:0] k_pos;
    logic [MAX_NZ-1:0]       k_sign;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  busy, done, nz_count, overflow, bad_digit, csd_err, k_pos, k_sign
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output busy, done, nz_count, overflow, bad_digit, csd_err, k_pos, k_sign
    );
endinterface

// File: rtl/csd_nz_scanner.sv
// Scans a CSD digit memory once per start and records index/sign of each nonzero digit.
// Optional adjacent-nonzero check enabled by defining CSD_ADJ_CHECK_EN.
module csd_nz_scanner #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned N_DIGITS = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned MAX_NZ   = 4,
    parameter int unsigned CNT_W    = 3
) (
    input logic              clk,
    input logic              reset,
    csd_nz_scanner_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StScan, StDone} stateT;

    localparam logic [DATA_W-1:0] DigitPos = DATA_W'(1);
    localparam logic [DATA_W-1:0] DigitNeg = '1;
    localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0]  MaxCnt   = CNT_W'(MAX_NZ);

    stateT                   stateQ, stateD;
    logic [DATA_W-1:0]       memQ [N_DIGITS];
    logic [IDX_W-1:0]        idxQ, idxD;
    logic [CNT_W-1:0]        cntQ, cntD;
    logic                    ovfQ, ovfD;
    logic                    badQ, badD;
    logic [MAX_NZ*IDX_W-1:0] kPosQ, kPosD;
    logic [MAX_NZ-1:0]       kSignQ, kSignD;
    logic [DATA_W-1:0]       digit;
    logic                    digitNz, digitNeg, digitBad;
    logic                    memWe;
    logic                    startAcc;

    assign digit    = memQ[idxQ];
    assign digitNeg = (digit == DigitNeg);
    assign digitNz  = (digit == DigitPos) || digitNeg;
    assign digitBad = !digitNz && (digit != '0);
    assign startAcc = (stateQ == StIdle) && bus.start;
    assign memWe    = (stateQ == StIdle) && bus.wr_en && (32'(bus.wr_addr) < N_DIGITS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned a = 0; a < N_DIGITS; a++) memQ[a] <= '0;
        end else if (memWe) begin
            memQ[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= StIdle;
            idxQ   <= '0;
            cntQ   <= '0;
            ovfQ   <= 1'b0;
            badQ   <= 1'b0;
            kPosQ  <= '0;
            kSignQ <= '0;
        end else begin
            stateQ <= stateD;
            idxQ   <= idxD;
            cntQ   <= cntD;
            ovfQ   <= ovfD;
            badQ   <= badD;
            kPosQ  <= kPosD;
            kSignQ <= kSignD;
        end
    end

    always_comb begin
        stateD = stateQ;
        idxD   = idxQ;
        cntD   = cntQ;
        ovfD   = ovfQ;
        badD   = badQ;
        kPosD  = kPosQ;
        kSignD = kSignQ;
        unique case (stateQ)
            StIdle: begin
                if (bus.start) begin
                    stateD = StScan;
                    idxD   = '0;
                    cntD   = '0;
                    ovfD   = 1'b0;
                    badD   = 1'b0;
                    kPosD  = '0;
                    kSignD = '0;
                end
            end
            StScan: begin
                if (digitNz) begin
                    if (cntQ < MaxCnt) begin
                        for (int unsigned s = 0; s < MAX_NZ; s++) begin
                            if (cntQ == CNT_W'(s)) begin
                                kPosD[s*IDX_W +: IDX_W] = idxQ;
                                kSignD[s]               = digitNeg;
                            end
                        end
                        cntD = cntQ + 1'b1;
                    end else begin
                        ovfD = 1'b1;
                    end
                end else if (digitBad) begin
                    badD = 1'b1;
                end
                // Stop on the last real digit so the counter never reaches unused addresses.
                if (idxQ == LastIdx) stateD = StDone;
                else                 idxD   = idxQ + 1'b1;
            end
            StDone: stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

`ifdef CSD_ADJ_CHECK_EN
    logic prevNzQ, prevNzD;
    logic csdQ, csdD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prevNzQ <= 1'b0;
            csdQ    <= 1'b0;
        end else begin
            prevNzQ <= prevNzD;
            csdQ    <= csdD;
        end
    end

    // Overflowed digits still count as nonzero here; bad digits count as zero.
    always_comb begin
        prevNzD = prevNzQ;
        csdD    = csdQ;
        if (startAcc) begin
            prevNzD = 1'b0;
            csdD    = 1'b0;
        end else if (stateQ == StScan) begin
            prevNzD = digitNz;
            if (digitNz && prevNzQ) csdD = 1'b1;
        end
    end

    assign bus.csd_err = csdQ;
`else
    assign bus.csd_err = 1'b0;
`endif

    assign bus.busy      = (stateQ != StIdle);
    assign bus.done      = (stateQ == StDone);
    assign bus.nz_count  = cntQ;
    assign bus.overflow  = ovfQ;
    assign bus.bad_digit = badQ;
    assign bus.k_pos     = kPosQ;
    assign bus.k_sign    = kSignQ;
endmodule

// File: tb/tb_csd_nz_scanner.sv
// Scoreboard bench for csd_nz_scanner: directed scans push expected results, a monitor
// checks them whenever done is presented.
module tb_csd_nz_scanner;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned N_DIGITS = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned MAX_NZ   = 4;
    localparam int unsigned CNT_W    = 3;
`ifdef CSD_ADJ_CHECK_EN
    localparam bit AdjEn = 1'b1;
`else
    localparam bit AdjEn = 1'b0;
`endif

    typedef struct packed {
        logic [CNT_W-1:0]        cnt;
        logic                    ovf;
        logic                    bad;
        logic                    csd;
        logic [MAX_NZ*IDX_W-1:0] kPos;
        logic [MAX_NZ-1:0]       kSign;
    } resT;

    logic clk;
    logic reset;
    int   nTests;
    int   nFail;
    resT  sb[$];

    csd_nz_scanner_if #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .MAX_NZ(MAX_NZ), .CNT_W(CNT_W)
    ) bus ();

    csd_nz_scanner #(
        .DATA_W(DATA_W), .N_DIGITS(N_DIGITS), .IDX_W(IDX_W), .MAX_NZ(MAX_NZ), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    initial begin
        resT e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    nTests++;
                    nFail++;
                    $display("FAIL unexpected_done: got done with no pending scan, expected none");
                end else begin
                    e = sb.pop_front();
                    check("nz_count", 32'(bus.nz_count), 32'(e.cnt));
                    check("overflow", 32'(bus.overflow), 32'(e.ovf));
                    check("bad_digit", 32'(bus.bad_digit), 32'(e.bad));
                    check("csd_err", 32'(bus.csd_err), 32'(e.csd));
                    check("k_pos", 32'(bus.k_pos), 32'(e.kPos));
                    check("k_sign", 32'(bus.k_sign), 32'(e.kSign));
                end
            end
        end
    end

    task automatic writeDigit(input int addr, input logic [DATA_W-1:0] data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = IDX_W'(addr);
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic clearMem();
        for (int a = 0; a < int'(N_DIGITS); a++) writeDigit(a, '0);
    endtask

    // Starts a scan (optionally with a same-edge write) and checks start-to-done latency.
    // pokeAt > 0 drives wr_en+start mid-scan, which must be ignored.
    task automatic runScan(input resT exp, input bit wr, input int addr,
                           input logic [DATA_W-1:0] data, input int pokeAt);
        int cyc;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.wr_en   = wr;
        bus.wr_addr = IDX_W'(addr);
        bus.wr_data = data;
        sb.push_back(exp);
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == pokeAt + 1 && pokeAt > 0) begin
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
            end
            @(negedge clk);
            if (bus.done === 1'b1) begin
                cyc = k;
                break;
            end
            if (k == pokeAt) begin
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_addr = '0;
                bus.wr_data = 8'h01;
            end
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check("done_latency", 32'(cyc), 32'(N_DIGITS));
    endtask

    initial begin
        resT e;
        nTests      = 0;
        nFail       = 0;
        reset       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        #12;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_nz_count", 32'(bus.nz_count), 0);
        check("rst_k_pos", 32'(bus.k_pos), 0);
        check("rst_k_sign", 32'(bus.k_sign), 0);
        check("rst_flags", {29'd0, bus.overflow, bus.bad_digit, bus.csd_err}, 0);
        @(negedge clk);
        reset = 1'b1;

        // All-zero memory.
        e = '{cnt: 3'd0, ovf: 1'b0, bad: 1'b0, csd: 1'b0, kPos: 16'h0000, kSign: 4'b0000};
        runScan(e, 1'b0, 0, '0, 0);

        // Three nonzero digits, one negative.
        writeDigit(1, 8'h01);
        writeDigit(4, 8'hFF);
        writeDigit(9, 8'h01);
        e = '{cnt: 3'd3, ovf: 1'b0, bad: 1'b0, csd: 1'b0, kPos: 16'h0941, kSign: 4'b0010};
        runScan(e, 1'b0, 0, '0, 0);

        // Five nonzero digits overflow four slots.
        clearMem();
        for (int i = 0; i <= 8; i += 2) writeDigit(i, 8'h01);
        e = '{cnt: 3'd4, ovf: 1'b1, bad: 1'b0, csd: 1'b0, kPos: 16'h6420, kSign: 4'b0000};
        runScan(e, 1'b0, 0, '0, 0);

        // Adjacent nonzero digits.
        clearMem();
        writeDigit(3, 8'h01);
        writeDigit(4, 8'hFF);
        e = '{cnt: 3'd2, ovf: 1'b0, bad: 1'b0, csd: AdjEn, kPos: 16'h0043, kSign: 4'b0010};
        runScan(e, 1'b0, 0, '0, 0);

        // Bad encoding; then the same scan with a write/start poked mid-scan.
        clearMem();
        writeDigit(5, 8'h02);
        e = '{cnt: 3'd0, ovf: 1'b0, bad: 1'b1, csd: 1'b0, kPos: 16'h0000, kSign: 4'b0000};
        runScan(e, 1'b0, 0, '0, 0);
        runScan(e, 1'b0, 0, '0, 5);
        repeat (3) @(negedge clk);
        runScan(e, 1'b0, 0, '0, 0);

        // Last index plus a write that lands on the start edge.
        clearMem();
        writeDigit(15, 8'hFF);
        e = '{cnt: 3'd2, ovf: 1'b0, bad: 1'b0, csd: 1'b0, kPos: 16'h00F7, kSign: 4'b0010};
        runScan(e, 1'b1, 7, 8'h01, 0);

        // Reset asserted mid-scan clears everything at once, including memory.
        writeDigit(2, 8'h01);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        check("midrst_nz_count", 32'(bus.nz_count), 0);
        check("midrst_k_pos", 32'(bus.k_pos), 0);
        check("midrst_k_sign", 32'(bus.k_sign), 0);
        @(negedge clk);
        reset = 1'b1;
        e = '{cnt: 3'd0, ovf: 1'b0, bad: 1'b0, csd: 1'b0, kPos: 16'h0000, kSign: 4'b0000};
        runScan(e, 1'b0, 0, '0, 0);

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
        $fatal(1, "watchdog");
    end
endmodule
